multicycle_control: RTL and testbench
=====================================

# multicycle_control

Control unit for the multi-cycle MIPS datapath. Decodes the current instruction word and sequences it through fetch, decode, execute, memory and writeback cycles. Drives every datapath select and enable, and handshakes with an optional iterative multiplier. It is the parametrised successor of the single-cycle decoder: same opcode/funct set and ALU encoding, plus optional ISA extensions, a multiplier wait state and a sticky illegal-instruction trap.

## Interface
Parameters:
- EN_EXT, default 1: enables bne, ori, lui, jal; when 0 these opcodes trap as illegal.
- EN_MUL, default 1: enables multu, mfhi, mflo; when 0 these functs trap.
- ALUCTL_W, default 3: alucontrol width, ≥3; upper bits are driven 0.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- instr  in  32  instruction register contents, valid from DECODE onward.
- zero  in  1  ALU result is zero.
- mul_done  in  1  multiplier finished; single-cycle pulse.
- pcwrite  out  1  unconditional PC load.
- dobranch  out  1  conditional PC load, already qualified by zero.
- iord  out  1  memory address from ALUOut (1) or PC (0).
- irwrite  out  1  load instruction register.
- memwrite  out  1  write data memory.
- memtoreg  out  1  writeback selects memory data.
- regwrite  out  1  write register file.
- destreg  out  5  destination register number.
- alusrca  out  1  ALU A operand: register (1) or PC (0).
- alusrcb  out  2  ALU B operand: 00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- immzext  out  1  zero-extend the immediate (ori).
- pcsrc  out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target.
- alucontrol  out  ALUCTL_W  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 sltu, 100 lui (B<<16).
- hilosel  out  2  writeback source: 00 ALU, 01 HI, 10 LO.
- mul_start  out  1  start multiplier; single-cycle pulse.
- illegal  out  1  sticky trap flag.

## Operation
- The FSM is Moore. All outputs are decoded from the state register and instr. dobranch is additionally qualified by zero.
- Every output not listed for a state is 0. destreg is 0 outside writeback states.
- States and transitions:
  - FETCH: iord=0, irwrite, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00, pcwrite. Next: DECODE.
  - DECODE: alusrcb=11, alucontrol=add, computes the branch target. Next state depends on op:
    - lw/sw → MEMADR
    - R-type → EXEC_R
    - addiu/ori/lui → EXEC_I
    - beq/bne → BRANCH
    - j/jal → JUMP
    - anything else → TRAP
  - MEMADR: alusrca=1, alusrcb=10, add. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD: iord=1 → MEMWB.
  - MEMWB: regwrite, memtoreg, destreg=instr[20:16] → FETCH.
  - MEMWR: iord=1, memwrite → FETCH.
  - EXEC_R: alusrca=1, alusrcb=00, alucontrol from funct:
    - 100001 add, 100011 sub, 100100 and, 100101 or, 101011 sltu.
    - 011001 (multu) → MULWAIT, with mul_start asserted in this state.
    - 010000 (mfhi) / 010010 (mflo) → ALUWB with hilosel=01 / 10.
    - other funct → TRAP.
    - All other legal functs → ALUWB.
  - ALUWB: regwrite, destreg=instr[15:11] → FETCH.
  - EXEC_I: alusrca=1, alusrcb=10; add, or+immzext, or lui → IWB.
  - IWB: regwrite, destreg=instr[20:16] → FETCH.
  - BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01. dobranch = zero for beq, ~zero for bne. Next: FETCH.
  - JUMP: pcsrc=10, pcwrite. For jal additionally regwrite, destreg=31, alusrca=0, alusrcb=00, hilosel=00; the link value is PC+4, already in PC. Next: FETCH.
  - MULWAIT: holds until mul_done, then FETCH.
  - TRAP: illegal=1, all enables 0. Absorbing until reset.
- Disabled extensions (EN_EXT=0 or EN_MUL=0) decode their opcodes/functs as illegal.

## Timing
- Reset (asynchronous, reset_n low): state=FETCH, illegal=0. Outputs show FETCH values immediately.
- Reset mid-instruction aborts the instruction. No memwrite or regwrite is issued after reset asserts.
- Cycles per instruction: lw 5; sw, R-type, addiu/ori/lui 4; beq/bne, j/jal 3; multu 3 + cycles until mul_done; mfhi/mflo 4.
- mul_done in the same cycle as mul_start is ignored. The earliest accepted mul_done is in the first MULWAIT cycle.
- mul_done outside MULWAIT is ignored.
- instr must be stable from DECODE until the return to FETCH.

## Structure
- Shared package mips_pkg:
  - opcode/funct localparams
  - ALU code constants
  - alusrcb/pcsrc/hilosel encodings
  - state enum state_t
- One natural sub-module: alu_decode, a combinational funct → alucontrol/legal/class mapping, reused by the pipelined core later.

## Test plan
- addu $3,$1,$2 (0x00221821): FETCH/DECODE/EXEC_R/ALUWB. alucontrol=010 in EXEC_R; regwrite=1, destreg=3 in cycle 4; back to FETCH in cycle 5.
- lw $5,8($4) then sw $5,12($4): 5 and 4 cycles. iord=1 exactly in MEMRD/MEMWR; memwrite only in MEMWR; memtoreg with destreg=5 in MEMWB.
- beq with zero=1 vs zero=0, then bne with both: dobranch = 1, 0, 0, 1 in the BRANCH cycle. pcsrc=01 in all four cases.
- jal (0x0C000010): JUMP cycle has pcwrite=1, pcsrc=10, regwrite=1, destreg=31.
- multu with mul_done after 7 cycles: mul_start is a single pulse in EXEC_R; the FSM stays in MULWAIT for 7 cycles and returns to FETCH the next cycle. A spurious mul_done in FETCH causes no effect.
- Opcode 0x3F, and EN_EXT=0 with lui: TRAP and illegal=1 held for 20 cycles. reset_n pulsed low mid-MEMWR: memwrite drops asynchronously; FETCH with illegal=0 after release.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcode/funct codes, ALU and mux encodings, controller state codes
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] HL_ALU = 2'b00;
    localparam logic [1:0] HL_HI  = 2'b01;
    localparam logic [1:0] HL_LO  = 2'b10;

    typedef enum logic [1:0] {FC_ALU, FC_MUL, FC_MFHI, FC_MFLO} fclass_t;

    typedef logic [3:0] state_t;
    localparam state_t S_FETCH   = 4'd0;
    localparam state_t S_DECODE  = 4'd1;
    localparam state_t S_MEMADR  = 4'd2;
    localparam state_t S_MEMRD   = 4'd3;
    localparam state_t S_MEMWB   = 4'd4;
    localparam state_t S_MEMWR   = 4'd5;
    localparam state_t S_EXEC_R  = 4'd6;
    localparam state_t S_ALUWB   = 4'd7;
    localparam state_t S_EXEC_I  = 4'd8;
    localparam state_t S_IWB     = 4'd9;
    localparam state_t S_BRANCH  = 4'd10;
    localparam state_t S_JUMP    = 4'd11;
    localparam state_t S_MULWAIT = 4'd12;
    localparam state_t S_TRAP    = 4'd13;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction/status inputs and datapath control outputs of the controller
interface multicycle_control_if #(parameter int ALUCTL_W = 3);
    logic [31:0]         instr;
    logic                zero;
    logic                mul_done;
    logic                pcwrite;
    logic                dobranch;
    logic                iord;
    logic                irwrite;
    logic                memwrite;
    logic                memtoreg;
    logic                regwrite;
    logic [4:0]          destreg;
    logic                alusrca;
    logic [1:0]          alusrcb;
    logic                immzext;
    logic [1:0]          pcsrc;
    logic [ALUCTL_W-1:0] alucontrol;
    logic [1:0]          hilosel;
    logic                mul_start;
    logic                illegal;

    modport master (
        input  instr, zero, mul_done,
        output pcwrite, dobranch, iord, irwrite, memwrite, memtoreg, regwrite, destreg,
               alusrca, alusrcb, immzext, pcsrc, alucontrol, hilosel, mul_start, illegal
    );
    modport slave (
        output instr, zero, mul_done,
        input  pcwrite, dobranch, iord, irwrite, memwrite, memtoreg, regwrite, destreg,
               alusrca, alusrcb, immzext, pcsrc, alucontrol, hilosel, mul_start, illegal
    );
endinterface

// File: rtl/multicycle_control_alu_decode.sv
// alu_decode: R-type funct to ALU operation, legality and instruction class
module alu_decode
    import mips_pkg::*;
#(
    parameter bit EN_MUL = 1'b1
) (
    input  logic [5:0] funct_i,
    output logic [2:0] alu_o,
    output logic       legal_o,
    output fclass_t    cls_o
);
    always_comb begin
        alu_o   = ALU_ADD;
        legal_o = 1'b1;
        cls_o   = FC_ALU;
        case (funct_i)
            FN_ADDU:  alu_o = ALU_ADD;
            FN_SUBU:  alu_o = ALU_SUB;
            FN_AND:   alu_o = ALU_AND;
            FN_OR:    alu_o = ALU_OR;
            FN_SLTU:  alu_o = ALU_SLTU;
            FN_MULTU: begin cls_o = FC_MUL;  legal_o = EN_MUL; end
            FN_MFHI:  begin cls_o = FC_MFHI; legal_o = EN_MUL; end
            FN_MFLO:  begin cls_o = FC_MFLO; legal_o = EN_MUL; end
            default:  legal_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the multi-cycle MIPS datapath, with
// optional ISA extensions, a multiplier wait state and an absorbing trap state
module multicycle_control
    import mips_pkg::*;
#(
    parameter bit EN_EXT   = 1'b1,
    parameter bit EN_MUL   = 1'b1,
    parameter int ALUCTL_W = 3
) (
    input logic                  clk,
    input logic                  reset_n,
    multicycle_control_if.master bus
);
    state_t     state_q, state_d;
    logic [5:0] op;
    logic [2:0] r_alu, alu;
    logic       r_legal, is_ext, unused_ok;
    fclass_t    r_cls;

    assign op        = bus.instr[31:26];
    assign is_ext    = op inside {OP_BNE, OP_ORI, OP_LUI, OP_JAL};
    assign unused_ok = ^{bus.instr[25:21], bus.instr[10:6]};

    alu_decode #(.EN_MUL(EN_MUL)) u_alu_decode (
        .funct_i(bus.instr[5:0]),
        .alu_o  (r_alu),
        .legal_o(r_legal),
        .cls_o  (r_cls)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state_q <= S_FETCH;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:              state_d = S_MEMADR;
                    OP_RTYPE:                  state_d = S_EXEC_R;
                    OP_ADDIU, OP_ORI, OP_LUI:  state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE:            state_d = S_BRANCH;
                    OP_J, OP_JAL:              state_d = S_JUMP;
                    default:                   state_d = S_TRAP;
                endcase
                if (is_ext && !EN_EXT) state_d = S_TRAP;
            end
            S_MEMADR:  state_d = op == OP_SW ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXEC_R:  state_d = !r_legal ? S_TRAP : r_cls == FC_MUL ? S_MULWAIT : S_ALUWB;
            S_EXEC_I:  state_d = S_IWB;
            // mul_done is only sampled here, so pulses during EXEC_R or elsewhere are dropped
            S_MULWAIT: state_d = bus.mul_done ? S_FETCH : S_MULWAIT;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.pcwrite   = 1'b0;
        bus.dobranch  = 1'b0;
        bus.iord      = 1'b0;
        bus.irwrite   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.memtoreg  = 1'b0;
        bus.regwrite  = 1'b0;
        bus.destreg   = 5'd0;
        bus.alusrca   = 1'b0;
        bus.alusrcb   = SRCB_REG;
        bus.immzext   = 1'b0;
        bus.pcsrc     = PC_ALU;
        bus.hilosel   = HL_ALU;
        bus.mul_start = 1'b0;
        bus.illegal   = 1'b0;
        alu           = ALU_AND;
        case (state_q)
            S_FETCH: begin
                bus.irwrite = 1'b1;
                bus.pcwrite = 1'b1;
                bus.alusrcb = SRCB_FOUR;
                alu         = ALU_ADD;
            end
            S_DECODE: begin
                bus.alusrcb = SRCB_IMMSH;
                alu         = ALU_ADD;
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
                alu         = ALU_ADD;
            end
            S_MEMRD: bus.iord = 1'b1;
            S_MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
                bus.destreg  = bus.instr[20:16];
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            S_EXEC_R: begin
                bus.alusrca   = 1'b1;
                bus.mul_start = r_legal && r_cls == FC_MUL;
                alu           = r_alu;
            end
            S_ALUWB: begin
                bus.regwrite = 1'b1;
                bus.destreg  = bus.instr[15:11];
                bus.hilosel  = r_cls == FC_MFHI ? HL_HI : r_cls == FC_MFLO ? HL_LO : HL_ALU;
            end
            S_EXEC_I: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
                bus.immzext = op == OP_ORI;
                alu         = op == OP_ORI ? ALU_OR : op == OP_LUI ? ALU_LUI : ALU_ADD;
            end
            S_IWB: begin
                bus.regwrite = 1'b1;
                bus.destreg  = bus.instr[20:16];
            end
            S_BRANCH: begin
                bus.alusrca  = 1'b1;
                bus.pcsrc    = PC_ALUOUT;
                bus.dobranch = op == OP_BNE ? ~bus.zero : bus.zero;
                alu          = ALU_SUB;
            end
            // jal links PC+4, which the FETCH increment already left in PC
            S_JUMP: begin
                bus.pcwrite  = 1'b1;
                bus.pcsrc    = PC_JUMP;
                bus.regwrite = op == OP_JAL;
                bus.destreg  = op == OP_JAL ? 5'd31 : 5'd0;
            end
            S_TRAP: bus.illegal = 1'b1;
            default: ;
        endcase
    end

    assign bus.alucontrol = ALUCTL_W'(alu);
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and random instructions checked cycle by cycle
// against per-instruction expected control lists built from the ISA rules
module tb_multicycle_control;
    typedef struct packed {
        logic       pcwrite, dobranch, iord, irwrite, memwrite, memtoreg, regwrite;
        logic [4:0] destreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       immzext;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic [1:0] hilosel;
        logic       mul_start, illegal;
    } ctl_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ctl_t eq[$], mq[$];
    bit   dq[$], zq[$];
    ctl_t o1, o2;
    logic [5:0] ops [11] = '{6'h00, 6'h23, 6'h2b, 6'h09, 6'h0d, 6'h0f, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3f};
    logic [5:0] fns [10] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2b, 6'h19, 6'h10, 6'h12, 6'h00, 6'h2a};

    multicycle_control_if b1 ();
    multicycle_control_if b2 ();

    multicycle_control dut1 (.clk(clk), .reset_n(reset_n), .bus(b1.master));
    multicycle_control #(.EN_EXT(1'b0), .EN_MUL(1'b0)) dut2 (.clk(clk), .reset_n(reset_n), .bus(b2.master));

    always #5 clk = ~clk;

    assign o1 = {b1.pcwrite, b1.dobranch, b1.iord, b1.irwrite, b1.memwrite, b1.memtoreg, b1.regwrite,
                 b1.destreg, b1.alusrca, b1.alusrcb, b1.immzext, b1.pcsrc, b1.alucontrol, b1.hilosel,
                 b1.mul_start, b1.illegal};
    assign o2 = {b2.pcwrite, b2.dobranch, b2.iord, b2.irwrite, b2.memwrite, b2.memtoreg, b2.regwrite,
                 b2.destreg, b2.alusrca, b2.alusrcb, b2.immzext, b2.pcsrc, b2.alucontrol, b2.hilosel,
                 b2.mul_start, b2.illegal};

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish before 300000");
        $fatal(1);
    end

    task automatic check(input string tag, input ctl_t obs, input ctl_t exp, input ctl_t msk);
        checks++;
        assert ((obs & msk) === (exp & msk)) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs & msk, exp & msk);
        end
    endtask

    function automatic ctl_t fetch_c();
        ctl_t c = '0;
        c.pcwrite = 1'b1; c.irwrite = 1'b1; c.alusrcb = 2'b01; c.alucontrol = 3'b010;
        return c;
    endfunction

    function automatic void add(input ctl_t c, input ctl_t m, input bit md, input bit z);
        eq.push_back(c); mq.push_back(m); dq.push_back(md); zq.push_back(z);
    endfunction

    function automatic bit rnd();
        return bit'($urandom_range(0, 1));
    endfunction

    // Expected control list for one instruction; returns 1 when it ends in the trap
    function automatic bit build(input logic [31:0] ins, input bit ext, input bit mul,
                                 input int lat, input int ntrap, input int bz);
        logic [5:0] op, fn;
        ctl_t c, m;
        bit trap, z, arith, is_mul, is_hi, is_lo;
        op = ins[31:26];
        fn = ins[5:0];
        eq = {}; mq = {}; dq = {}; zq = {};
        trap = 1'b0;
        add(fetch_c(), '1, 1'b1, rnd());
        c = '0; c.alusrcb = 2'b11; c.alucontrol = 3'b010;
        add(c, '1, rnd(), rnd());
        if (!ext && op inside {6'h05, 6'h0d, 6'h0f, 6'h03}) trap = 1'b1;
        else if (op == 6'h23 || op == 6'h2b) begin
            c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = 3'b010;
            add(c, '1, rnd(), rnd());
            c = '0; c.iord = 1'b1; c.memwrite = op == 6'h2b;
            add(c, '1, rnd(), rnd());
            if (op == 6'h23) begin
                c = '0; c.regwrite = 1'b1; c.memtoreg = 1'b1; c.destreg = ins[20:16];
                add(c, '1, rnd(), rnd());
            end
        end else if (op == 6'h00) begin
            c = '0; c.alusrca = 1'b1; m = '1;
            arith = 1'b1;
            case (fn)
                6'h21: c.alucontrol = 3'b010;
                6'h23: c.alucontrol = 3'b110;
                6'h24: c.alucontrol = 3'b000;
                6'h25: c.alucontrol = 3'b001;
                6'h2b: c.alucontrol = 3'b111;
                default: begin arith = 1'b0; m.alucontrol = '0; end
            endcase
            is_mul = mul && fn == 6'h19;
            is_hi  = mul && fn == 6'h10;
            is_lo  = mul && fn == 6'h12;
            c.mul_start = is_mul;
            add(c, m, rnd(), rnd());
            if (!(arith || is_mul || is_hi || is_lo)) trap = 1'b1;
            else if (is_mul) begin
                for (int k = 1; k <= lat; k++) add('0, '1, k == lat, rnd());
            end else begin
                c = '0; c.regwrite = 1'b1; c.destreg = ins[15:11];
                c.hilosel = is_hi ? 2'b01 : is_lo ? 2'b10 : 2'b00;
                add(c, '1, rnd(), rnd());
            end
        end else if (op inside {6'h09, 6'h0d, 6'h0f}) begin
            c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10; c.immzext = op == 6'h0d;
            c.alucontrol = op == 6'h0d ? 3'b001 : op == 6'h0f ? 3'b100 : 3'b010;
            add(c, '1, rnd(), rnd());
            c = '0; c.regwrite = 1'b1; c.destreg = ins[20:16];
            add(c, '1, rnd(), rnd());
        end else if (op == 6'h04 || op == 6'h05) begin
            z = bz < 0 ? rnd() : bit'(bz);
            c = '0; c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01;
            c.dobranch = op == 6'h04 ? z : !z;
            add(c, '1, rnd(), z);
        end else if (op == 6'h02 || op == 6'h03) begin
            c = '0; c.pcwrite = 1'b1; c.pcsrc = 2'b10;
            if (op == 6'h03) begin c.regwrite = 1'b1; c.destreg = 5'd31; end
            add(c, '1, rnd(), rnd());
        end else trap = 1'b1;
        if (trap) begin
            c = '0; c.illegal = 1'b1;
            for (int k = 0; k < ntrap; k++) add(c, '1, rnd(), rnd());
        end
        return trap;
    endfunction

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check({tag, " rst1"}, o1, fetch_c(), '1);
        check({tag, " rst2"}, o2, fetch_c(), '1);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic run(input string tag, input logic [31:0] ins, input bit which, input int abort_at);
        b1.instr = ins;
        b2.instr = ins;
        for (int i = 0; i < eq.size(); i++) begin
            b1.zero = zq[i]; b2.zero = zq[i];
            b1.mul_done = dq[i]; b2.mul_done = dq[i];
            #1;
            check($sformatf("%s c%0d", tag, i), which ? o2 : o1, eq[i], mq[i]);
            if (i == abort_at) begin
                #1 reset_n = 1'b0;
                #1 check({tag, " async"}, which ? o2 : o1, fetch_c(), '1);
                @(posedge clk);
                #2;
                check({tag, " held"}, which ? o2 : o1, fetch_c(), '1);
                reset_n = 1'b1;
                return;
            end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic t(input string tag, input logic [31:0] ins, input bit which, input int lat,
                     input int ntrap, input int bz);
        bit trapped;
        trapped = which ? build(ins, 1'b0, 1'b0, lat, ntrap, bz) : build(ins, 1'b1, 1'b1, lat, ntrap, bz);
        run(tag, ins, which, -1);
        if (trapped) do_reset(tag);
    endtask

    initial begin
        logic [31:0] ins;
        b1.instr = '0; b2.instr = '0;
        b1.zero = 1'b0; b2.zero = 1'b0;
        b1.mul_done = 1'b0; b2.mul_done = 1'b0;
        #1;
        check("reset1", o1, fetch_c(), '1);
        check("reset2", o2, fetch_c(), '1);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        t("x0 addu", 32'h00221821, 1'b1, 1, 3, -1);
        t("x0 multu", 32'h00220019, 1'b1, 1, 5, -1);
        t("x0 lui", 32'h3C091234, 1'b1, 1, 20, -1);
        t("x0 ori", 32'h35290005, 1'b1, 1, 2, -1);
        t("x0 bne", 32'h14220004, 1'b1, 1, 2, -1);
        t("x0 jal", 32'h0C000010, 1'b1, 1, 2, -1);
        t("x0 mflo", 32'h00004012, 1'b1, 1, 2, -1);

        t("addu", 32'h00221821, 1'b0, 1, 3, -1);
        t("lw", 32'h8C850008, 1'b0, 1, 3, -1);
        t("sw", 32'hAC85000C, 1'b0, 1, 3, -1);
        t("beq z1", 32'h10220004, 1'b0, 1, 3, 1);
        t("beq z0", 32'h10220004, 1'b0, 1, 3, 0);
        t("bne z1", 32'h14220004, 1'b0, 1, 3, 1);
        t("bne z0", 32'h14220004, 1'b0, 1, 3, 0);
        t("jal", 32'h0C000010, 1'b0, 1, 3, -1);
        t("j", 32'h08000010, 1'b0, 1, 3, -1);
        t("multu", 32'h00220019, 1'b0, 7, 3, -1);
        t("mfhi", 32'h00003810, 1'b0, 1, 3, -1);
        t("mflo", 32'h00004012, 1'b0, 1, 3, -1);
        t("lui", 32'h3C091234, 1'b0, 1, 3, -1);
        t("ori", 32'h35290005, 1'b0, 1, 3, -1);
        t("addiu", 32'h2422FFFF, 1'b0, 1, 3, -1);
        t("op3f", 32'hFC000000, 1'b0, 1, 20, -1);

        void'(build(32'hAC85000C, 1'b1, 1'b1, 1, 3, -1));
        run("sw abort", 32'hAC85000C, 1'b0, 3);
        t("after abort", 32'h00221821, 1'b0, 1, 3, -1);

        for (int n = 0; n < 200; n++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 10)];
            if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 9)];
            t($sformatf("rnd%0d %h", n, ins), ins, 1'b0, int'($urandom_range(1, 6)), 3, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
